// File: rtl/mult_par_seq.sv
// Parity-checked iterative shift-add multiplier with per-transaction signed/unsigned
// mode, req/ack/result_rdy handshake, busy flag and saturating parity-error counter.
`timescale 1ns/1ps
module mult_par_seq #(
   parameter int DATA_W    = 16,
   parameter int ERR_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic [DATA_W-1:0]      arg_a,
   input  logic                   arg_a_parity,
   input  logic [DATA_W-1:0]      arg_b,
   input  logic                   arg_b_parity,
   input  logic                   signed_mode,
   output logic                   ack,
   output logic [2*DATA_W-1:0]    result,
   output logic                   result_parity,
   output logic                   result_rdy,
   output logic                   arg_parity_error,
   output logic                   busy,
   output logic [ERR_CNT_W-1:0]   err_cnt
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [DATA_W-1:0] LAST_ITER = DATA_W'(DATA_W - 1);

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     cnt_q;
   logic [DATA_W-1:0]     mplier_q;
   logic [2*DATA_W-1:0]   mcand_q;
   logic [2*DATA_W-1:0]   acc_q;
   logic                  neg_q;
   logic                  perr_q;

   logic [DATA_W-1:0]     mag_a, mag_b;
   logic                  parity_ok;
   logic [2*DATA_W-1:0]   prod;

   // Magnitudes are kept unsigned so that the most negative operand maps to 2^(DATA_W-1).
   always_comb begin
      mag_a     = (signed_mode && arg_a[DATA_W-1]) ? -arg_a : arg_a;
      mag_b     = (signed_mode && arg_b[DATA_W-1]) ? -arg_b : arg_b;
      parity_ok = (arg_a_parity == ^arg_a) && (arg_b_parity == ^arg_b);
      prod      = neg_q ? -acc_q : acc_q;
   end

   always_comb begin
      // NOTE: default assigned first so no path through the case can infer a latch.
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = parity_ok ? CALC : DONE;
         CALC:    if (cnt_q == LAST_ITER) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack              <= 1'b0;
         result           <= '0;
         result_parity    <= 1'b0;
         result_rdy       <= 1'b0;
         arg_parity_error <= 1'b0;
         err_cnt          <= '0;
         cnt_q            <= '0;
         mplier_q         <= '0;
         mcand_q          <= '0;
         acc_q            <= '0;
         neg_q            <= 1'b0;
         perr_q           <= 1'b0;
      end else begin
         ack        <= 1'b0;
         result_rdy <= 1'b0;
         case (state_q)
            IDLE: if (req) begin
               ack      <= 1'b1;
               mcand_q  <= {{DATA_W{1'b0}}, mag_a};
               mplier_q <= mag_b;
               acc_q    <= '0;
               cnt_q    <= '0;
               neg_q    <= signed_mode & (arg_a[DATA_W-1] ^ arg_b[DATA_W-1]);
               perr_q   <= ~parity_ok;
            end
            CALC: begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + DATA_W'(1);
            end
            DONE: begin
               result_rdy       <= 1'b1;
               arg_parity_error <= perr_q;
               if (perr_q) begin
                  result        <= '0;
                  result_parity <= 1'b0;
                  if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
               end else begin
                  result        <= prod;
                  result_parity <= ^prod;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_par_seq.sv
// Scoreboard bench for mult_par_seq: expected responses are queued at drive time and
// compared against each result_rdy pulse, with latency and handshake checks.
`timescale 1ns/1ps
module tb_mult_par_seq;
   localparam int W  = 16;
   localparam int EW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            req;
   logic [W-1:0]    arg_a, arg_b;
   logic            arg_a_parity, arg_b_parity;
   logic            signed_mode;
   logic            ack;
   logic [2*W-1:0]  result;
   logic            result_parity;
   logic            result_rdy;
   logic            arg_parity_error;
   logic            busy;
   logic [EW-1:0]   err_cnt;

   mult_par_seq #(.DATA_W(W), .ERR_CNT_W(EW)) dut (
      .clk(clk), .rst(rst), .req(req),
      .arg_a(arg_a), .arg_a_parity(arg_a_parity),
      .arg_b(arg_b), .arg_b_parity(arg_b_parity),
      .signed_mode(signed_mode), .ack(ack),
      .result(result), .result_parity(result_parity),
      .result_rdy(result_rdy), .arg_parity_error(arg_parity_error),
      .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] res;
      logic           par;
      logic           perr;
      logic [EW-1:0]  ec;
      int             lat;
   } exp_t;

   exp_t          sb_q[$];
   int            n_chk = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            last_ack_cyc = 0;
   int            last_rdy_cyc = -100;
   int            n_rdy = 0;
   logic          prev_rdy = 1'b0;
   logic [EW-1:0] exp_ec = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every result_rdy pulse against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ack) last_ack_cyc = cyc;
         if (result_rdy) begin
            check("rdy_with_ack", 64'(ack), 64'd0);
            check("rdy_twice", 64'(prev_rdy), 64'd0);
            check("rdy_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("result", 64'(result), 64'(e.res));
               check("result_parity", 64'(result_parity), 64'(e.par));
               check("arg_parity_error", 64'(arg_parity_error), 64'(e.perr));
               check("err_cnt", 64'(err_cnt), 64'(e.ec));
               check("latency", 64'(cyc - last_ack_cyc), 64'(e.lat));
            end
            last_rdy_cyc = cyc;
            n_rdy++;
         end
         prev_rdy = result_rdy;
      end
   end

   // Drives one request (called at a negedge), queues the expected response, waits for ack.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       input bit bad_a, input bit bad_b, input bit keep, input bit b2b);
      exp_t e;
      logic signed [2*W-1:0] sa, sb, sp;
      logic [2*W-1:0] ua, ub;
      int n;
      arg_a        = a;
      arg_b        = b;
      arg_a_parity = (^a) ^ bad_a;
      arg_b_parity = (^b) ^ bad_b;
      signed_mode  = sm;
      req          = 1'b1;
      if (bad_a || bad_b) begin
         e.res  = '0;
         e.perr = 1'b1;
         e.lat  = 1;
         if (exp_ec != '1) exp_ec = exp_ec + 1'b1;
      end else begin
         if (sm) begin
            sa = $signed(a);
            sb = $signed(b);
            sp = sa * sb;
            e.res = sp;
         end else begin
            ua = a;
            ub = b;
            e.res = ua * ub;
         end
         e.perr = 1'b0;
         e.lat  = W + 1;
      end
      e.par = ^e.res;
      e.ec  = exp_ec;
      sb_q.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack && n < 100);
      check("ack_seen", 64'(ack), 64'd1);
      if (b2b) check("b2b_ack_cycle", 64'(cyc), 64'(last_rdy_cyc + 1));
      if (!keep) req = 1'b0;
      @(negedge clk);
      check("ack_one_cycle", 64'(ack), 64'd0);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb_q.size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int rdy_before;
      rst = 1'b1; req = 1'b0; arg_a = '0; arg_b = '0;
      arg_a_parity = 1'b0; arg_b_parity = 1'b0; signed_mode = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_rdy", 64'(result_rdy), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      send(16'd3,    16'hFFFE, 1'b1, 0, 0, 0, 0); wait_done();
      check("spec_signed", 64'(result), 64'hFFFF_FFFA);
      send(16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 0, 0); wait_done();
      check("spec_unsigned_ext", 64'(result), 64'hFFFE_0001);
      send(16'h8000, 16'h8000, 1'b1, 0, 0, 0, 0); wait_done();
      check("spec_signed_ext", 64'(result), 64'h4000_0000);
      send(16'h1234, 16'hF00D, 1'b1, 0, 0, 0, 0); wait_done();
      send(16'h8001, 16'h0005, 1'b0, 0, 0, 0, 0); wait_done();
      send(16'd5,    16'd2,    1'b0, 1, 0, 0, 0); wait_done();
      send(16'd5,    16'd2,    1'b0, 0, 1, 0, 0); wait_done();
      check("spec_err_cnt2", 64'(err_cnt), 64'd2);

      // Reset in the middle of CALC: in-flight result must be dropped.
      send(16'd1234, 16'd567, 1'b0, 0, 0, 0, 0);
      repeat (4) @(negedge clk);
      check("busy_mid_calc", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_ack", 64'(ack), 64'd0);
      check("rst_mid_result", 64'(result), 64'd0);
      check("rst_mid_parity", 64'(result_parity), 64'd0);
      check("rst_mid_rdy", 64'(result_rdy), 64'd0);
      check("rst_mid_perr", 64'(arg_parity_error), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_err_cnt", 64'(err_cnt), 64'd0);
      sb_q.delete();
      exp_ec = '0;
      @(negedge clk);
      rst = 1'b0;
      rdy_before = n_rdy;
      repeat (25) @(negedge clk);
      check("no_rdy_after_rst", 64'(n_rdy), 64'(rdy_before));

      send(16'd7, 16'd6, 1'b0, 0, 0, 0, 0); wait_done();
      check("spec_42", 64'(result), 64'd42);

      // Back-to-back parity errors with req held high; counter saturates at 3.
      send(16'd5, 16'd2, 1'b0, 1, 0, 1, 0);
      send(16'd9, 16'd3, 1'b1, 0, 1, 1, 1);
      send(16'd5, 16'd2, 1'b0, 1, 1, 1, 1);
      send(16'd4, 16'd4, 1'b0, 1, 0, 0, 1);
      wait_done();
      check("sat_err_cnt", 64'(err_cnt), 64'd3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
